// File: rtl/r8_seq_mult_ctrl.sv
// r8_seq_mult_ctrl
// Sequential controller for a radix-8 Booth multiplier that time-shares one
// partial-product generator. One Booth digit is recoded and accumulated per
// cycle, so a full 16x16 signed product takes six RUN cycles.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   in_a, in_b          signed multiplicand / multiplier
//   gen_a               latched multiplicand driven to the generator
//   prod0..prod4        generator outputs 0, A, 2A, 3A, 4A (32-bit, sign-extended)
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   out_p               accumulator / signed product
//   busy                high while digits are being accumulated
//   dig_idx             digit currently being accumulated (0 outside RUN)
module r8_seq_mult_ctrl #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] gen_a,
  input  logic [31:0] prod0,
  input  logic [31:0] prod1,
  input  logic [31:0] prod2,
  input  logic [31:0] prod3,
  input  logic [31:0] prod4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        busy,
  output logic [2:0]  dig_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] a_r;
  // Multiplier with the implicit b[-1]=0 appended at bit 0. It is shifted
  // right arithmetically by 3 per digit, so the current digit window is
  // always bits [3:0] and bits above 18-3i are copies of the sign.
  logic [18:0] b_sh;
  logic [31:0] acc;

  logic [3:0]  win;
  logic [2:0]  mag;
  logic        neg;
  logic [31:0] sel_p;
  logic [31:0] term;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic        rest_eq;
  logic        last_dig;

  assign gen_a    = a_r;
  assign out_p    = acc;
  assign in_ready = (state == IDLE) && !rst;

  // Booth recoding of the current 4-bit window into magnitude and sign,
  // then selection, conditional negation and alignment of the term.
  always_comb begin
    win = b_sh[3:0];
    mag = 3'd0;
    unique case (win)
      4'b0000, 4'b1111: mag = 3'd0;
      4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = 3'd1;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = 3'd2;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = 3'd3;
      4'b0111, 4'b1000: mag = 3'd4;
      default: mag = 3'd0;
    endcase
    // 1111 is digit zero, not a negative digit
    neg = win[3] & ~(&win);
    sel_p = prod0;
    unique case (mag)
      3'd1:    sel_p = prod1;
      3'd2:    sel_p = prod2;
      3'd3:    sel_p = prod3;
      3'd4:    sel_p = prod4;
      default: sel_p = prod0;
    endcase
    term    = neg ? (~sel_p + 32'd1) : sel_p;
    shamt   = 5'(dig_idx) * 5'd3;
    shifted = term << shamt;
    // All remaining multiplier bits equal means every later digit is zero
    rest_eq  = (b_sh[18:3] == 16'h0000) || (b_sh[18:3] == 16'hFFFF);
    last_dig = (dig_idx == 3'd5) || (SKIP_ZERO && rest_eq);
  end

  // Control FSM with registered busy/out_valid/dig_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= 16'd0;
      b_sh      <= 19'd0;
      acc       <= 32'd0;
      dig_idx   <= 3'd0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= in_a;
            b_sh    <= {in_b[15], in_b[15], in_b, 1'b0};
            acc     <= 32'd0;
            dig_idx <= 3'd0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc  <= acc + shifted;
          b_sh <= {{3{b_sh[18]}}, b_sh[18:3]};
          if (last_dig) begin
            dig_idx   <= 3'd0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            dig_idx <= dig_idx + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/r8_seq_mult_ctrl.md
# r8_seq_mult_ctrl

Sequential controller for the radix-8 approximate Booth multiplier datapath. It accepts a signed 16x16 operand pair over a valid/ready handshake and drives the multiplicand into the partial-product generator. Each cycle it recodes one radix-8 Booth digit of the multiplier, selects the generator's 0/A/2A/3A/4A output, conditionally negates and shifts it, and accumulates it into a 32-bit result. It time-shares one generator instance across all six digits, in place of a parallel Wallace-tree array.

## Interface
Parameters:
- SKIP_ZERO, default 0: when 1, the run terminates early once all remaining Booth digits are zero.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands (IDLE only).
- in_a  input  16  signed multiplicand.
- in_b  input  16  signed multiplier.
- gen_a  output  16  multiplicand to the generator; equals the latched A register.
- prod0..prod4  input  32 each  generator outputs: 0, A, 2A, 3A, 4A, sign-extended to 32 bits.
- out_valid  output  1  result valid (DONE state).
- out_ready  input  1  consumer accepts result.
- out_p  output  32  signed product (accumulator).
- busy  output  1  high in RUN.
- dig_idx  output  3  index of the digit being accumulated in RUN (0..5); 0 otherwise.

## Operation
- States: IDLE, RUN, DONE. Reset drives the block to IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a_r=in_a. Latch b_ext (18 bits) = {in_b[15], in_b[15], in_b} with b[-1]=0. Clear acc=0, dig_idx=0, then go to RUN.
- RUN, digit i: bits (b[3i+2], b[3i+1], b[3i], b[3i-1]). Value d = -4*b[3i+2] + 2*b[3i+1] + b[3i] + b[3i-1], range -4..+4.
  - Magnitude |d| selects prod0..prod4. neg = b[3i+2] & ~(all four bits equal).
  - term = neg ? (~p + 1) : p, in 32 bits. acc <= acc + (term << 3i), mod 2^32.
- RUN exit: after i==5 is accumulated, go to DONE.
  - With SKIP_ZERO=1, also go to DONE after digit i if b_ext[17:3i+2] are all equal, because every remaining digit is then zero.
  - With SKIP_ZERO=0, RUN always lasts exactly 6 cycles.
- DONE: out_valid=1 and out_p=acc, held stable while out_ready=0. On out_valid&&out_ready, go to IDLE.
- Input capture: in_a and in_b are sampled only on the accept edge. Later input changes have no effect.
- gen_a: always a_r. The generator is combinational, so prodN is consumed in the same cycle it is selected.
- Correctness: with an exact generator (prod3=3A), out_p = in_a*in_b exactly. With the approximate generator, only digits of magnitude 3 carry error.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 after it (IDLE); out_valid=0; out_p=0; busy=0; dig_idx=0; gen_a=0.
- Reset mid-RUN or mid-DONE aborts the run: acc is cleared and the pending result is discarded.
- Accept on edge k. Accumulation edges k+1..k+6 with SKIP_ZERO=0; out_valid is visible after edge k+6.
- Result handshake on edge k+7 at the earliest. The next accept is at edge k+8 at the earliest, giving a minimum interval of 8 cycles per product.
- SKIP_ZERO=1: the number of RUN cycles is n, with 1 ≤ n ≤ 6; out_valid is visible after edge k+n.
- No overlap between jobs: in_ready=0 throughout RUN and DONE, even if out_ready is high.
- in_valid is ignored outside IDLE. The upstream must hold in_valid and its data until in_ready is seen.

## Test plan
The bench models the generator exactly (prod3=3*A) unless stated.
- A=3, B=5 (digits -3, +1): out_p=0x0000000F, exactly 6 RUN cycles, and dig_idx steps 0..5.
- A=-32768, B=-32768: out_p=0x40000000. A=32767, B=-32768: out_p=0xC0008000.
- SKIP_ZERO=1, A=1234, B=1: out_valid after 1 RUN cycle with out_p=1234. Also, B=0: 1 RUN cycle with out_p=0, and B=-1: 1 RUN cycle with out_p=-1234.
- Backpressure: out_ready held 0 for 5 cycles in DONE. out_p stays stable and in_ready stays 0; in_valid pulses are ignored. Release gives the handshake, then IDLE, then the next accept.
- Reset mid-RUN (at dig_idx=3) followed by a new job A=-7, B=9: all outputs return to reset values, and the new result is 0xFFFFFFC1 with no residue from the aborted job.
- Random signed pairs with back-to-back jobs (5000 each, SKIP_ZERO 0 and 1): the result matches A*B. With the approximate generator model plugged in, the error is nonzero only when some digit has |d|=3.
